// File: rtl/scan_pq_if.sv
// scan_pq_if: client/device bundle for the scan_pq priority queue.
interface scan_pq_if #(parameter int KW = 4, parameter int VW = 4);
    localparam int W = KW + VW;
    logic         enq;
    logic         deq;
    logic [W-1:0] kvi;
    logic [W-1:0] kvo;
    logic         full;
    logic         empty;
    logic         busy;
    modport master (output enq, deq, kvi, input kvo, full, empty, busy);
    modport slave  (input enq, deq, kvi, output kvo, full, empty, busy);
endinterface

// File: rtl/scan_pq.sv
// scan_pq: register-array priority queue, lowest key first, ties in arrival order.
// Enqueue tracks the minimum on the fly; dequeue compacts then rescans one entry per cycle.
module scan_pq #(
    parameter int KW    = 4,
    parameter int VW    = 4,
    parameter int DEPTH = 8
) (
    input logic       clk,
    input logic       rst,
    scan_pq_if.slave  pq
);
    localparam int W  = KW + VW;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        r_state;
    logic [W-1:0]  r_ent [DEPTH];
    logic [CW-1:0] r_count;
    logic [IW-1:0] r_min, r_sp, r_best;
    logic          w_full, w_empty, w_busy, w_enq, w_deq, w_new_min, w_sp_less, w_last;

    assign w_full    = r_count == CW'(DEPTH);
    assign w_empty   = r_count == '0;
    assign w_busy    = r_state == SCAN;
    assign w_deq     = pq.deq && !w_busy && !w_empty;
    assign w_enq     = pq.enq && !pq.deq && !w_busy && !w_full;
    assign w_new_min = w_empty || (pq.kvi[W-1:VW] < r_ent[r_min][W-1:VW]);
    // strict less-than keeps the older entry on equal keys
    assign w_sp_less = r_ent[r_sp][W-1:VW] < r_ent[r_best][W-1:VW];
    assign w_last    = CW'(r_sp) == r_count - CW'(1);

    assign pq.full  = w_full;
    assign pq.empty = w_empty;
    assign pq.busy  = w_busy;
    assign pq.kvo   = (w_empty || w_busy) ? '0 : r_ent[r_min];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_min   <= '0;
            r_sp    <= '0;
            r_best  <= '0;
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
        end else if (r_state == SCAN) begin
            r_best <= w_sp_less ? r_sp : r_best;
            r_sp   <= r_sp + IW'(1);
            if (w_last) begin
                r_min   <= w_sp_less ? r_sp : r_best;
                r_state <= IDLE;
            end
        end else if (w_deq) begin
            for (int i = 0; i < DEPTH - 1; i++)
                if (i >= int'(r_min)) r_ent[i] <= r_ent[i+1];
            r_ent[DEPTH-1] <= '0;
            r_count        <= r_count - CW'(1);
            r_sp           <= '0;
            r_best         <= '0;
            if (r_count != CW'(1)) r_state <= SCAN;
        end else if (w_enq) begin
            for (int i = 0; i < DEPTH; i++)
                if (i == int'(r_count)) r_ent[i] <= pq.kvi;
            r_count <= r_count + CW'(1);
            if (w_new_min) r_min <= IW'(r_count);
        end
    end
endmodule

// File: tb/tb_scan_pq.sv
// tb_scan_pq: random and directed stimulus against a stable min-queue model.
module tb_scan_pq;
    logic clk = 0;
    logic rst_n = 0;
    bit   chk_en = 0;
    int   pass = 0;
    int   total = 0;
    logic [7:0] mq[$];
    int   mbusy = 0;

    scan_pq_if #(.KW(4), .VW(4)) pq();
    scan_pq #(.KW(4), .VW(4), .DEPTH(8)) dut (.clk(clk), .rst(rst_n), .pq(pq));

    always #5 clk = ~clk;

    function automatic int argmin();
        int b = 0;
        for (int i = 1; i < mq.size(); i++) if (mq[i][7:4] < mq[b][7:4]) b = i;
        return b;
    endfunction

    function automatic logic [7:0] model_kvo();
        return (mq.size() == 0 || mbusy > 0) ? 8'h00 : mq[argmin()];
    endfunction

    // reference: a queue in arrival order; dequeue takes the first minimum key
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mbusy = 0;
        end else if (mbusy > 0) mbusy--;
        else if (pq.deq) begin
            if (mq.size() > 0) begin
                mq.delete(argmin());
                mbusy = mq.size();
            end
        end else if (pq.enq && mq.size() < 8) mq.push_back(pq.kvi);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("kvo",   pq.kvo,         model_kvo());
        chk("empty", 8'(pq.empty),   8'(mq.size() == 0));
        chk("full",  8'(pq.full),    8'(mq.size() == 8));
        chk("busy",  8'(pq.busy),    8'(mbusy > 0));
    end

    task automatic cyc(input logic e, input logic d, input logic [7:0] kv);
        pq.enq = e;
        pq.deq = d;
        pq.kvi = kv;
        @(negedge clk);
        pq.enq = 0;
        pq.deq = 0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (pq.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("busy_timeout", 8'(n), 8'd0);
    endtask

    task automatic drain();
        int n;
        for (int g = 0; g < 10 && !pq.empty; g++) begin
            cyc(0, 1, 8'h00);
            wait_idle(n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] tie_exp [3];
        tie_exp = '{8'h2C, 8'h4A, 8'h4B};
        pq.enq = 0; pq.deq = 0; pq.kvi = 0;
        repeat (3) @(negedge clk);
        chk("rst_kvo",   pq.kvo,       8'h00);
        chk("rst_empty", 8'(pq.empty), 8'd1);
        chk("rst_full",  8'(pq.full),  8'd0);
        chk("rst_busy",  8'(pq.busy),  8'd0);
        rst_n = 1;
        chk_en = 1;
        @(negedge clk);

        cyc(1, 0, 8'h51); cyc(1, 0, 8'h32); cyc(1, 0, 8'h73);
        chk("min3_kvo",  pq.kvo,      8'h32);
        chk("min3_busy", 8'(pq.busy), 8'd0);
        cyc(0, 1, 8'h00);
        wait_idle(n);
        chk("deq_busy_cycles", 8'(n), 8'd2);
        chk("after_deq_kvo",   pq.kvo, 8'h51);
        drain();

        cyc(1, 0, 8'h4A); cyc(1, 0, 8'h4B); cyc(1, 0, 8'h2C);
        for (int i = 0; i < 3; i++) begin
            chk("tie_order", pq.kvo, tie_exp[i]);
            cyc(0, 1, 8'h00);
            wait_idle(n);
        end
        chk("tie_empty", 8'(pq.empty), 8'd1);
        chk("tie_kvo",   pq.kvo,       8'h00);

        for (int i = 0; i < 8; i++) cyc(1, 0, {4'(i + 2), 4'(i)});
        chk("fill_full", 8'(pq.full), 8'd1);
        cyc(1, 0, 8'h0F);
        chk("ovf_kvo",  pq.kvo,      8'h20);
        chk("ovf_full", 8'(pq.full), 8'd1);
        cyc(0, 1, 8'h00);
        chk("deq_full_clears", 8'(pq.full), 8'd0);
        wait_idle(n);
        chk("full_deq_busy", 8'(n), 8'd7);
        chk("full_deq_kvo",  pq.kvo, 8'h31);

        cyc(0, 1, 8'h00);
        cyc(1, 0, 8'h00);
        cyc(0, 1, 8'h00);
        wait_idle(n);
        chk("busy_ignore_kvo", pq.kvo, 8'h42);
        cyc(1, 1, 8'h00);
        wait_idle(n);
        chk("both_deq_only", pq.kvo, 8'h53);
        drain();
        cyc(0, 1, 8'h00);
        chk("deq_empty_busy", 8'(pq.busy), 8'd0);
        chk("deq_empty_kvo",  pq.kvo,      8'h00);

        cyc(1, 0, 8'h91); cyc(1, 0, 8'h82); cyc(1, 0, 8'hA3);
        cyc(0, 1, 8'h00);
        chk("pre_rst_busy", 8'(pq.busy), 8'd1);
        #2 rst_n = 0;
        #1;
        chk("async_busy",  8'(pq.busy),  8'd0);
        chk("async_empty", 8'(pq.empty), 8'd1);
        chk("async_full",  8'(pq.full),  8'd0);
        chk("async_kvo",   pq.kvo,       8'h00);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 200; i++) begin
            int r = $urandom_range(0, 99);
            cyc(r < 55, r >= 50, 8'($urandom));
        end
        drain();
        chk_en = 0;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
